// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fetch_pkg;

   localparam int INSTR_W = 32;

   // instruction field positions: {opcode, Ra, Rb, Rd, imm}
   localparam int OPC_MSB = 31;
   localparam int RA_MSB  = 27;
   localparam int RB_MSB  = 23;
   localparam int RD_MSB  = 19;
   localparam int IMM_MSB = 15;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DROP
   } fetch_state_t;

   // one queued fetch result: the word and the address it came from
   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] word;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count and flush.
// Latency: a pushed entry can reach the head output the cycle after the push.
// Backpressure: caller never pushes when full; flush empties it and overrides push/pop.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   assign dout = mem[rd_ptr];

   // storage, pointers and count; a flush keeps rd_ptr so the head output holds its last value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= rd_ptr;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one imem read at a time and queues {pc, word} for the core.
// Latency: word reaches the head the cycle after imem_rvalid; best case one instruction per 2 cycles.
// Backpressure: no request while the queue is full (outstanding read keeps a slot); redirect flushes.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_N = CW'(DEPTH);
   localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

   fetch_state_t  state, state_nxt;
   logic [31:0]   fetch_pc, fetch_pc_nxt, req_pc;
   logic [CW-1:0] count;
   logic [CW:0]   count_after;
   logic          push, pop, room_after;
   fetch_entry_t  push_entry, head_entry;
   logic          unused_redirect_lsb;

   // low address bits carry no meaning for word fetches
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign pop         = instr_valid && instr_ready;
   assign push        = (state == WAIT) && imem_rvalid && !redirect;
   assign count_after = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
   assign room_after  = count_after < DEPTH_W;

   assign imem_req    = (state == REQ);
   assign imem_addr   = fetch_pc;
   assign instr_valid = (count != '0);
   assign instruction = head_entry.word;
   assign instr_pc    = head_entry.pc;

   assign push_entry.pc   = req_pc;
   assign push_entry.word = imem_rdata;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect),
      .push  (push),
      .pop   (pop),
      .din   (push_entry),
      .dout  (head_entry),
      .count (count)
   );

   // state, fetch PC, and the PC of the read currently in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         if (state == REQ && imem_gnt) req_pc <= fetch_pc;
      end
   end

   // next state and PC; redirect wins over every other event in its cycle
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      if (redirect)                     fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
      else if (state == REQ && imem_gnt) fetch_pc_nxt = fetch_pc + 32'd4;
      case (state)
         IDLE: if (redirect || count < DEPTH_N) state_nxt = REQ;
         REQ:  if (imem_gnt) state_nxt = redirect ? DROP : WAIT;
         WAIT: begin
            if (imem_rvalid)   state_nxt = (redirect || room_after) ? REQ : IDLE;
            else if (redirect) state_nxt = DROP;
         end
         DROP: if (imem_rvalid) state_nxt = REQ;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed table, corner sequences, randomized run vs. model.
// Latency: inputs change away from edges; outputs sampled at negedge or 1 unit after posedge.
// Backpressure: memory grant/latency and core ready are randomized or scripted per test.
module tb_instr_fetch;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] XOR_K  = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst, redirect, imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, instruction, instr_pc;

   instr_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instruction(instruction), .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rpc;
      int unsigned lat;
      logic [31:0] exp_a1;
      logic [31:0] exp_a2;
   } redir_vec_t;
   redir_vec_t tbl [4];

   // reference model: expected queue contents, PC and single outstanding read
   logic [63:0] q[$];
   logic        pend, pend_drop, exp_req;
   logic [31:0] pend_addr, exp_pc, last_gnt;
   // memory environment
   bit          mem_busy, force_rv;
   logic [31:0] mem_addr;
   int          mem_wait;
   int unsigned gnt_pct, lat_min, lat_max;
   // bookkeeping
   int cyc, n_pop, n_gnt, first_pop, n_pass, n_total;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic mem_drive();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (force_rv) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hDEAD_BEEF;
         force_rv    = 1'b0;
      end else if (mem_busy) begin
         mem_wait--;
         if (mem_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_addr ^ XOR_K;
            mem_busy    = 1'b0;
         end
      end else if (imem_req && ($urandom_range(99) < gnt_pct)) begin
         imem_gnt = 1'b1;
         mem_busy = 1'b1;
         mem_addr = imem_addr;
         mem_wait = $urandom_range(lat_max, lat_min);
      end
   endtask

   task automatic model_step();
      logic gnt_ev, rv_ev, rv_drop, pop_ev;
      int   size0;
      chk("imem_req", 64'(imem_req), 64'(exp_req));
      if (exp_req) chk("imem_addr", 64'(imem_addr), 64'(exp_pc));
      chk("instr_valid", 64'(instr_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         chk("instr_pc", 64'(instr_pc), 64'(q[0][63:32]));
         chk("instruction", 64'(instruction), 64'(q[0][31:0]));
      end
      size0   = q.size();
      gnt_ev  = imem_req && imem_gnt;
      rv_ev   = imem_rvalid && pend;
      rv_drop = pend_drop || redirect;
      pop_ev  = (size0 != 0) && instr_ready;
      if (pop_ev && !redirect) begin
         n_pop++;
         if (first_pop < 0) first_pop = cyc;
      end
      if (redirect) q.delete();
      else begin
         if (pop_ev) void'(q.pop_front());
         if (rv_ev && !rv_drop) q.push_back({pend_addr, pend_addr ^ XOR_K});
      end
      if (rv_ev) pend = 1'b0;
      if (pend && redirect) pend_drop = 1'b1;
      if (gnt_ev) begin
         n_gnt++;
         last_gnt  = imem_addr;
         pend      = 1'b1;
         pend_addr = exp_pc;
         pend_drop = redirect;
      end
      if (redirect)    exp_pc = {redirect_pc[31:2], 2'b00};
      else if (gnt_ev) exp_pc = exp_pc + 32'd4;
      if (pend)          exp_req = 1'b0;
      else if (redirect) exp_req = 1'b1;
      else if (rv_ev)    exp_req = rv_drop ? 1'b1 : (q.size() < DEPTH);
      else if (exp_req)  exp_req = 1'b1;
      else               exp_req = (size0 < DEPTH);
      cyc++;
   endtask

   task automatic cycle();
      @(negedge clk);
      mem_drive();
      model_step();
      @(posedge clk);
      #1;
      redirect = 1'b0;
   endtask

   task automatic wait_gnt(input string name);
      int n0 = n_gnt;
      int k  = 0;
      while (n_gnt == n0 && k < 64) begin
         cycle();
         k++;
      end
      if (n_gnt == n0) begin
         n_total++;
         $display("FAIL %s: no grant within 64 cycles", name);
      end
   endtask

   task automatic do_reset(input bit check);
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      if (check) begin
         chk("rst_req", 64'(imem_req), 64'(0));
         chk("rst_addr", 64'(imem_addr), 64'(RST_PC));
         chk("rst_valid", 64'(instr_valid), 64'(0));
         chk("rst_instr", 64'(instruction), 64'(0));
         chk("rst_pc", 64'(instr_pc), 64'(0));
      end
      rst = 1'b0;
      mem_busy = 1'b0; force_rv = 1'b0; q.delete();
      pend = 1'b0; pend_drop = 1'b0; exp_pc = RST_PC; exp_req = 1'b0;
      cyc = 0; n_pop = 0; n_gnt = 0; first_pop = -1;
      gnt_pct = 100; lat_min = 1; lat_max = 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_pass = 0; n_total = 0;
      tbl[0] = '{32'h0000_0103, 3, 32'h0000_0100, 32'h0000_0104};
      tbl[1] = '{32'h0000_0040, 1, 32'h0000_0040, 32'h0000_0044};
      tbl[2] = '{32'hFFFF_FFFF, 2, 32'hFFFF_FFFC, 32'h0000_0000};
      tbl[3] = '{32'h0000_0002, 4, 32'h0000_0000, 32'h0000_0004};

      // streaming: immediate grant, 1-cycle data, core always ready
      do_reset(1'b1);
      instr_ready = 1'b1;
      repeat (21) cycle();
      chk("stream_first_pop_cycle", 64'(first_pop), 64'(3));
      chk("stream_pops_in_21", 64'(n_pop), 64'(9));

      // core stalled: queue fills with 4 words, requests stop, then resume at 16
      do_reset(1'b0);
      repeat (20) cycle();
      chk("full_grants", 64'(n_gnt), 64'(4));
      chk("full_req_low", 64'(imem_req), 64'(0));
      instr_ready = 1'b1;
      wait_gnt("full_resume");
      chk("full_resume_addr", 64'(last_gnt), 64'(32'h10));

      // redirect the cycle after a grant, with several response latencies
      for (int i = 0; i < 4; i++) begin
         do_reset(1'b0);
         lat_min = tbl[i].lat; lat_max = tbl[i].lat;
         instr_ready = 1'b1;
         wait_gnt("tbl_first");
         redirect = 1'b1; redirect_pc = tbl[i].rpc;
         wait_gnt("tbl_a1");
         chk("tbl_a1", 64'(last_gnt), 64'(tbl[i].exp_a1));
         wait_gnt("tbl_a2");
         chk("tbl_a2", 64'(last_gnt), 64'(tbl[i].exp_a2));
      end

      // redirect coinciding with rvalid and a pop while two words are queued
      do_reset(1'b0);
      repeat (6) cycle();
      instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
      cycle();
      chk("rdr_rv_valid", 64'(instr_valid), 64'(0));
      chk("rdr_rv_req", 64'(imem_req), 64'(1));
      chk("rdr_rv_hold_pc", 64'(instr_pc), 64'(0));
      chk("rdr_rv_hold_instr", 64'(instruction), 64'(XOR_K));

      // grant held low 5 cycles, redirect to 0x40 in the second
      do_reset(1'b0);
      gnt_pct = 0; instr_ready = 1'b1;
      cycle(); cycle();
      redirect = 1'b1; redirect_pc = 32'h0000_0040;
      cycle();
      repeat (3) cycle();
      gnt_pct = 100;
      wait_gnt("stall_gnt");
      chk("stall_addr", 64'(last_gnt), 64'(32'h40));
      chk("stall_one_grant", 64'(n_gnt), 64'(1));
      cycle();
      chk("stall_valid", 64'(instr_valid), 64'(1));
      chk("stall_pc", 64'(instr_pc), 64'(32'h40));

      // reset while waiting on a read; the late response must vanish
      do_reset(1'b0);
      repeat (6) cycle();
      #1 rst = 1'b1;
      #1;
      chk("arst_req", 64'(imem_req), 64'(0));
      chk("arst_addr", 64'(imem_addr), 64'(RST_PC));
      chk("arst_valid", 64'(instr_valid), 64'(0));
      chk("arst_instr", 64'(instruction), 64'(0));
      chk("arst_pc", 64'(instr_pc), 64'(0));
      do_reset(1'b0);
      force_rv = 1'b1;
      instr_ready = 1'b0;
      repeat (3) cycle();
      chk("arst_first_valid", 64'(instr_valid), 64'(1));
      chk("arst_first_pc", 64'(instr_pc), 64'(RST_PC));
      chk("arst_first_instr", 64'(instruction), 64'(RST_PC ^ XOR_K));

      // randomized traffic against the model
      do_reset(1'b0);
      gnt_pct = 70; lat_min = 1; lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         instr_ready = ($urandom_range(99) < ((i < 1500) ? 70 : 20));
         if ($urandom_range(99) < 4) begin
            redirect    = 1'b1;
            redirect_pc = $urandom;
         end
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
